// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the decode/control stage.
// master = fetch unit side, slave = memory + decode side.
interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        decode_ready;
    logic [15:0] instr;
    logic [2:0]  opcode;
    logic [15:0] instr_pc;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [15:0] instr_count;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, instr_count,
        input  imem_ack, imem_rdata, decode_ready, branch, zero, jump
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, instr_count,
        output imem_ack, imem_rdata, decode_ready, branch, zero, jump
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch/issue stage: one outstanding imem request per instruction, valid/ready issue,
// next PC resolved from the Branch/Jump/zero result sampled at consume.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            enable,
    instruction_fetch_unit_if.master        bus
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] addr_q, addr_n;
    logic [15:0] instr_q, instr_n;
    logic [15:0] ipc_q, ipc_n;
    logic [15:0] cnt_q, cnt_n;
    logic        req_q, req_n;
    logic        valid_q, valid_n;
    logic [15:0] pc1;
    logic [15:0] next_pc;
    logic        consume;

    assign consume = valid_q & bus.decode_ready;
    assign pc1     = ipc_q + 16'd1;

    // Jump keeps the upper three bits of the incremented PC and wins over branch.
    always_comb begin
        if (bus.jump)
            next_pc = {pc1[15:13], instr_q[12:0]};
        else if (bus.branch & bus.zero)
            next_pc = pc1 + {{9{instr_q[6]}}, instr_q[6:0]};
        else
            next_pc = pc1;
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        addr_n  = addr_q;
        instr_n = instr_q;
        ipc_n   = ipc_q;
        cnt_n   = cnt_q;
        req_n   = req_q;
        valid_n = valid_q;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = FETCH;
                    req_n   = 1'b1;
                    addr_n  = pc;
                end
            end
            FETCH: begin
                if (req_q & bus.imem_ack) begin
                    instr_n = bus.imem_rdata;
                    ipc_n   = pc;
                    req_n   = 1'b0;
                    valid_n = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (consume) begin
                    pc_n    = next_pc;
                    cnt_n   = cnt_q + 16'd1;
                    valid_n = 1'b0;
                    if (enable) begin
                        state_n = FETCH;
                        req_n   = 1'b1;
                        addr_n  = next_pc;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= '0;
            ipc_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            addr_q  <= addr_n;
            instr_q <= instr_n;
            ipc_q   <= ipc_n;
            cnt_q   <= cnt_n;
            req_q   <= req_n;
            valid_q <= valid_n;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[15:13];
    assign bus.instr_pc    = ipc_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: the driver queues expected fetch addresses
// and issued words; a negedge monitor pops and compares on every handshake.
module tb_instruction_fetch_unit;
    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic enable = 1'b0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] word;
        int unsigned wt;
        int unsigned stall;
        logic br, z, jmp, drop_en;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] word;
    } iss_t;

    logic [15:0] req_q[$];
    iss_t        iss_q[$];
    vec_t        vecs[16];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_hs = 1'b0;
    logic [15:0] prev_addr = '0;
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
            prev_hs  = 1'b0;
        end else begin
            if (prev_req && !prev_ack) begin
                chk("req_held", {15'd0, bus.imem_req}, 16'd1);
                chk("addr_held", bus.imem_addr, prev_addr);
            end
            if (prev_hs) begin
                chk("valid_after_ack", {15'd0, bus.instr_valid}, 16'd1);
                chk("req_drop_after_ack", {15'd0, bus.imem_req}, 16'd0);
            end
            if (bus.imem_req && bus.imem_ack) begin
                if (req_q.size() == 0) chk("unexpected_req", bus.imem_addr, 16'hxxxx);
                else chk("imem_addr", bus.imem_addr, req_q.pop_front());
            end
            if (bus.instr_valid && !bus.decode_ready) begin
                chk("stall_no_req", {15'd0, bus.imem_req}, 16'd0);
                if (iss_q.size() != 0) chk("stall_instr", bus.instr, iss_q[0].word);
            end
            if (bus.instr_valid && bus.decode_ready) begin
                if (iss_q.size() == 0) chk("unexpected_issue", bus.instr, 16'hxxxx);
                else begin
                    iss_t e;
                    logic [15:0] w;
                    e = iss_q.pop_front();
                    w = e.word;
                    chk("instr", bus.instr, w);
                    chk("instr_pc", bus.instr_pc, e.addr);
                    chk("opcode", {13'd0, bus.opcode}, {13'd0, w[15:13]});
                end
            end
            prev_req  = bus.imem_req;
            prev_ack  = bus.imem_ack;
            prev_addr = bus.imem_addr;
            prev_hs   = bus.imem_req & bus.imem_ack;
        end
    end

    task automatic run_instr(input vec_t v);
        int unsigned n;
        iss_t e;
        e.addr = v.addr;
        e.word = v.word;
        req_q.push_back(v.addr);
        iss_q.push_back(e);
        n = 0;
        while (!bus.imem_req && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!bus.imem_req) begin
            chk("req_timeout", 16'd0, 16'd1);
            return;
        end
        if (v.drop_en) enable = 1'b0;
        repeat (v.wt) begin @(posedge clock); #1; end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = v.word;
        @(posedge clock); #1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'hDEAD;
        repeat (v.stall) begin @(posedge clock); #1; end
        bus.decode_ready = 1'b1;
        bus.branch = v.br;
        bus.zero   = v.z;
        bus.jump   = v.jmp;
        @(posedge clock); #1;
        bus.decode_ready = 1'b0;
        bus.branch = 1'b0;
        bus.zero   = 1'b0;
        bus.jump   = 1'b0;
    endtask

    initial begin
        int unsigned c0;
        //            addr      word     wt stall br  z  jmp drop
        vecs[0]  = '{16'h0000, 16'h2001, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{16'h0001, 16'h4002, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{16'h0002, 16'h6003, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{16'h0003, 16'h8004, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{16'h0004, 16'hA010, 3, 4, 0, 0, 1, 0};
        vecs[5]  = '{16'h0010, 16'hC07E, 0, 0, 1, 1, 0, 0};
        vecs[6]  = '{16'h000F, 16'hA010, 0, 0, 0, 0, 1, 0};
        vecs[7]  = '{16'h0010, 16'hC07E, 0, 0, 1, 0, 0, 0};
        vecs[8]  = '{16'h0011, 16'hE000, 0, 0, 0, 0, 1, 0};
        vecs[9]  = '{16'h0000, 16'h0040, 0, 0, 1, 1, 0, 0};
        vecs[10] = '{16'hFFC1, 16'hA005, 0, 0, 1, 1, 1, 0};
        vecs[11] = '{16'hE005, 16'h4123, 0, 0, 1, 1, 1, 0};
        vecs[12] = '{16'hE123, 16'h1FFF, 0, 0, 0, 0, 1, 0};
        vecs[13] = '{16'hFFFF, 16'h2222, 0, 0, 0, 0, 0, 0};
        vecs[14] = '{16'h0000, 16'h3333, 2, 1, 0, 0, 0, 1};
        vecs[15] = '{16'h0000, 16'h5555, 1, 0, 0, 0, 0, 0};

        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.decode_ready = 1'b0;
        bus.branch = 1'b0;
        bus.zero = 1'b0;
        bus.jump = 1'b0;

        // Reset held with enable and ack asserted.
        #1 reset_n = 1'b0;
        enable = 1'b1;
        bus.imem_ack = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req", {15'd0, bus.imem_req}, 16'd0);
        chk("rst_valid", {15'd0, bus.instr_valid}, 16'd0);
        chk("rst_addr", bus.imem_addr, 16'h0000);
        chk("rst_count", bus.instr_count, 16'h0000);
        chk("rst_instr", bus.instr, 16'h0000);
        chk("rst_opcode", {13'd0, bus.opcode}, 16'h0000);
        chk("rst_instr_pc", bus.instr_pc, 16'h0000);
        bus.imem_ack = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        run_instr(vecs[0]);
        c0 = cyc;
        for (int i = 1; i <= 3; i++) run_instr(vecs[i]);
        chk("throughput_cycles", 16'(cyc - c0), 16'd6);
        chk("count_after_4", bus.instr_count, 16'd4);
        for (int i = 4; i <= 14; i++) run_instr(vecs[i]);
        chk("count_after_15", bus.instr_count, 16'd15);
        for (int i = 0; i < 3; i++) begin
            chk("idle_no_req", {15'd0, bus.imem_req}, 16'd0);
            @(posedge clock); #1;
        end

        // Re-enable, then reset while the request is pending.
        enable = 1'b1;
        begin
            int unsigned n = 0;
            while (!bus.imem_req && n < 20) begin
                @(posedge clock); #1;
                n++;
            end
        end
        chk("req_before_rst", {15'd0, bus.imem_req}, 16'd1);
        chk("addr_before_rst", bus.imem_addr, 16'h0001);
        #2;
        reset_n = 1'b0;
        enable = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'hBEEF;
        #1;
        chk("async_rst_req", {15'd0, bus.imem_req}, 16'd0);
        chk("async_rst_addr", bus.imem_addr, 16'h0000);
        chk("async_rst_count", bus.instr_count, 16'h0000);
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("late_ack_req", {15'd0, bus.imem_req}, 16'd0);
            chk("late_ack_valid", {15'd0, bus.instr_valid}, 16'd0);
        end
        bus.imem_ack = 1'b0;
        enable = 1'b1;
        run_instr(vecs[15]);
        chk("count_after_rst", bus.instr_count, 16'd1);
        @(posedge clock); #1;
        chk("req_q_drained", 16'(req_q.size()), 16'd0);
        chk("iss_q_drained", 16'(iss_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch and issue stage of the 16-bit processor. It drives the instruction-memory request, captures the returned 16-bit word, and presents the opcode and word to the decode/control stage with a valid/ready handshake. It then takes the resolved Branch/Jump/zero result back from that stage to pick the next PC. Each instruction completes in at most one outstanding memory request. The PC is word-addressed.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- enable  in  1  fetch permission; low stops new requests.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  16  word address for the request.
- imem_ack  in  1  memory response strobe; valid only while imem_req=1.
- imem_rdata  in  16  instruction word, sampled when imem_req & imem_ack.
- instr_valid  out  1  instr/opcode/instr_pc hold a valid instruction.
- decode_ready  in  1  decode consumes the instruction this cycle.
- instr  out  16  instruction register.
- opcode  out  3  instr[15:13]; feeds the control unit.
- instr_pc  out  16  address of the issued instruction.
- branch  in  1  control unit Branch; sampled at consume.
- zero  in  1  ALU zero flag; sampled at consume.
- jump  in  1  control unit Jump; sampled at consume.
- instr_count  out  16  count of consumed instructions; wraps.

## Operation
- Field layout used for redirects:
  - I-type imm7 = instr[6:0], sign-extended to 16 bits.
  - J-type addr13 = instr[12:0].
- FSM states:
  - IDLE → FETCH when enable=1.
  - FETCH: imem_req=1, imem_addr=pc; on imem_ack capture imem_rdata into instr, set instr_pc=pc, go to ISSUE.
  - ISSUE: instr_valid=1. On decode_ready, pc←next_pc and instr_count+1. Then go to FETCH if enable=1, else IDLE.
- next_pc is computed from pc1 = instr_pc+1 (mod 2^16):
  - jump=1: {pc1[15:13], addr13}. Jump takes priority over branch.
  - else branch & zero: pc1 + sext(imm7), mod 2^16.
  - else: pc1.
- branch, jump and zero are ignored outside the consume cycle (instr_valid & decode_ready).
- enable dropping during FETCH does not abort the request. The outstanding fetch completes, is issued, and the FSM then goes to IDLE.
- imem_ack while imem_req=0 is ignored.
- PC wraps 0xFFFF → 0x0000.

## Timing
- Reset values (applied asynchronously):
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=0, opcode=0, instr_pc=0, instr_count=0.
- imem_req and imem_addr are registered. Once imem_req rises, both hold stable until the cycle imem_ack=1 is sampled. imem_req falls the cycle after ack.
- A same-cycle ack is legal: req at edge N, ack during N → instr_valid=1 from N+1.
- Best-case throughput is one instruction per 2 cycles: FETCH with immediate ack, then ISSUE with decode_ready=1.
- Backpressure: while instr_valid=1 and decode_ready=0, instr, opcode, instr_pc and pc are all frozen, and no request is issued.
- The redirect takes effect on the next request: the imem_addr of the following FETCH equals next_pc.
- opcode is always equal to instr[15:13], including during reset.
- reset_n low mid-FETCH or mid-ISSUE forces reset values immediately. The dropped memory response must be ignored: after reset deassertion, imem_req stays low until the FSM re-enters FETCH.

## Test plan
- Reset: hold reset_n=0 with enable=1 and imem_ack=1 → imem_req=0, instr_valid=0, pc/imem_addr=0x0000, instr_count=0.
- Sequential fetch: enable=1, memory acks in the request cycle, decode_ready=1, no branch/jump → imem_addr sequence 0x0000, 0x0001, 0x0002, 0x0003 on every other cycle; instr_count=4 after four consumes.
- Wait states and backpressure:
  - ack arrives 3 cycles after req → imem_addr and imem_req stable for all 4 cycles; instr_valid=1 the cycle after ack.
  - decode_ready=0 for 4 cycles → instr held; no new req.
- Branch: instr at 0x0010 with imm7=7'h7E, branch=1.
  - zero=1 → next imem_addr=0x000F.
  - zero=0 → next imem_addr=0x0011.
- Jump and wrap:
  - instr at 0xE005 with addr13=0x0123, jump=1 (branch=1, zero=1 also asserted) → next imem_addr=0xE123.
  - Sequential instr at 0xFFFF → next imem_addr=0x0000.
- Enable/reset mid-operation:
  - enable drops during a pending FETCH → request completes, instruction issues, FSM idles with imem_req=0.
  - reset_n pulsed low with imem_req=1 → imem_req=0 immediately; a late ack is ignored.
